// File: rtl/debouncer_multi.sv
// Multi-channel input debouncer: per-channel 2-FF synchroniser, stability filter,
// registered rise/fall pulses and a one-shot long-press detector.
module debouncer_multi #(
   parameter int   CHANNELS      = 4,
   parameter int   STABLE_CYCLES = 10,
   parameter int   LONG_CYCLES   = 1000,
   parameter logic INIT_LEVEL    = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] signal,
   output logic [CHANNELS-1:0] debounced,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] long_press
);

   localparam int            CW       = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic          ff1;
      logic          sync_q;
      logic          deb_q;
      logic          rise_q;
      logic          fall_q;
      logic          lp_q;
      logic [CW-1:0] cnt;

      // Any sample matching the current level discards progress toward a change.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            ff1    <= INIT_LEVEL;
            sync_q <= INIT_LEVEL;
            deb_q  <= INIT_LEVEL;
            cnt    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            ff1    <= signal[i];
            sync_q <= ff1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync_q == deb_q) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               deb_q  <= sync_q;
               cnt    <= '0;
               rise_q <= sync_q;
               fall_q <= ~sync_q;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      if (LONG_CYCLES > 0) begin : g_long
         localparam int            HW    = $clog2(LONG_CYCLES + 1);
         localparam logic [HW-1:0] HMAX  = HW'(LONG_CYCLES);
         localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);
         logic [HW-1:0] hcnt;

         // hcnt saturates at HMAX so a single press yields exactly one pulse.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               hcnt <= '0;
               lp_q <= 1'b0;
            end else if (!deb_q) begin
               hcnt <= '0;
               lp_q <= 1'b0;
            end else if (hcnt != HMAX) begin
               hcnt <= hcnt + 1'b1;
               lp_q <= (hcnt == HLAST);
            end else begin
               lp_q <= 1'b0;
            end
         end
      end else begin : g_no_long
         assign lp_q = 1'b0;
      end

      assign debounced[i]  = deb_q;
      assign rise[i]       = rise_q;
      assign fall[i]       = fall_q;
      assign long_press[i] = lp_q;
   end

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi: pulse events are scoreboarded by cycle
// stamp, level checks are made inline by each scenario task.
module tb_debouncer_multi;

   localparam int W = 44;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] signal;
   logic [3:0] debounced;
   logic [3:0] rise;
   logic [3:0] fall;
   logic [3:0] long_press;

   int cyc = 0;
   int checks = 0;
   int passes = 0;
   logic [W-1:0] exp_q[$];

   debouncer_multi #(
      .CHANNELS(4), .STABLE_CYCLES(10), .LONG_CYCLES(50), .INIT_LEVEL(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .signal(signal), .debounced(debounced),
      .rise(rise), .fall(fall), .long_press(long_press)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] ev(input int c, input logic [3:0] r,
                                       input logic [3:0] f, input logic [3:0] l);
      return {c, r, f, l};
   endfunction

   // scoreboard: every cycle carrying a pulse must match the next expected event
   always @(negedge clk) begin
      logic [W-1:0] obs;
      logic [W-1:0] e;
      if ((rise | fall | long_press) !== 4'b0) begin
         obs = {cyc, rise, fall, long_press};
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_pulse: got cyc=%0d r=%b f=%b lp=%b, expected none",
                     cyc, rise, fall, long_press);
         end else begin
            e = exp_q.pop_front();
            if (obs !== e)
               $display("FAIL pulse_event: got cyc=%0d r=%b f=%b lp=%b, expected cyc=%0d r=%b f=%b lp=%b",
                        cyc, rise, fall, long_press, e[43:12], e[11:8], e[7:4], e[3:0]);
            else
               passes++;
         end
      end
   end

   // driver tasks
   task automatic wait_to(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      signal = 4'h0;
      repeat (10) @(negedge clk);
      checks++;
      if ({debounced, rise, fall, long_press} !== 16'h0)
         $display("FAIL reset_outputs: got deb=%b r=%b f=%b lp=%b, expected all 0",
                  debounced, rise, fall, long_press);
      else passes++;
      reset = 1'b0;
      repeat (15) @(negedge clk);
      checks++;
      if (debounced !== 4'h0)
         $display("FAIL reset_release_level: got %b, expected 0000", debounced);
      else passes++;
   endtask

   task automatic test_toggle_then_hold;
      int c;
      for (int i = 0; i < 10; i++) begin
         signal[0] = (i % 2 == 0);
         @(negedge clk);
      end
      signal[0] = 1'b1;
      c = cyc;
      exp_q.push_back(ev(c + 12, 4'b0001, 4'b0000, 4'b0000));
      wait_to(c + 11);
      checks++;
      if (debounced !== 4'b0000)
         $display("FAIL toggle_early: got %b, expected 0000", debounced);
      else passes++;
      wait_to(c + 12);
      checks++;
      if (debounced !== 4'b0001)
         $display("FAIL toggle_rise_level: got %b, expected 0001", debounced);
      else passes++;
      wait_to(c + 30);
      signal[0] = 1'b0;
      exp_q.push_back(ev(c + 42, 4'b0000, 4'b0001, 4'b0000));
      wait_to(c + 44);
      checks++;
      if (debounced !== 4'b0000)
         $display("FAIL toggle_release_level: got %b, expected 0000", debounced);
      else passes++;
   endtask

   task automatic test_short_pulse;
      int c;
      signal[1] = 1'b1;
      c = cyc;
      wait_to(c + 5);
      signal[1] = 1'b0;
      wait_to(c + 25);
      checks++;
      if (debounced !== 4'b0000)
         $display("FAIL short_pulse_level: got %b, expected 0000", debounced);
      else passes++;
   endtask

   task automatic test_long_press;
      int c;
      signal[2] = 1'b1;
      c = cyc;
      exp_q.push_back(ev(c + 12, 4'b0100, 4'b0000, 4'b0000));
      exp_q.push_back(ev(c + 62, 4'b0000, 4'b0000, 4'b0100));
      exp_q.push_back(ev(c + 92, 4'b0000, 4'b0100, 4'b0000));
      wait_to(c + 61);
      checks++;
      if (long_press !== 4'b0000)
         $display("FAIL long_press_early: got %b, expected 0000", long_press);
      else passes++;
      wait_to(c + 80);
      signal[2] = 1'b0;
      wait_to(c + 91);
      checks++;
      if (debounced !== 4'b0100)
         $display("FAIL long_hold_level: got %b, expected 0100", debounced);
      else passes++;
      wait_to(c + 92);
      checks++;
      if (debounced !== 4'b0000)
         $display("FAIL long_release_level: got %b, expected 0000", debounced);
      else passes++;
      wait_to(c + 150);
   endtask

   task automatic test_simultaneous;
      int c;
      signal = 4'b1001;
      c = cyc;
      exp_q.push_back(ev(c + 12, 4'b1001, 4'b0000, 4'b0000));
      exp_q.push_back(ev(c + 32, 4'b0000, 4'b1001, 4'b0000));
      wait_to(c + 12);
      checks++;
      if (debounced !== 4'b1001)
         $display("FAIL simul_rise_level: got %b, expected 1001", debounced);
      else passes++;
      wait_to(c + 20);
      signal = 4'b0000;
      wait_to(c + 34);
      checks++;
      if (debounced !== 4'b0000)
         $display("FAIL simul_release_level: got %b, expected 0000", debounced);
      else passes++;
   endtask

   task automatic test_reset_mid_count;
      int c1;
      int c;
      int d;
      signal[1] = 1'b1;
      c1 = cyc;
      exp_q.push_back(ev(c1 + 12, 4'b0010, 4'b0000, 4'b0000));
      wait_to(c1 + 14);
      signal[0] = 1'b1;
      c = cyc;
      wait_to(c + 8);
      checks++;
      if (debounced !== 4'b0010)
         $display("FAIL mid_pre_reset_level: got %b, expected 0010", debounced);
      else passes++;
      reset = 1'b1;
      #1;
      checks++;
      if ({debounced, rise, fall, long_press} !== 16'h0)
         $display("FAIL async_reset_clear: got deb=%b r=%b f=%b lp=%b, expected all 0",
                  debounced, rise, fall, long_press);
      else passes++;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      d = cyc;
      exp_q.push_back(ev(d + 12, 4'b0011, 4'b0000, 4'b0000));
      wait_to(d + 11);
      checks++;
      if (debounced !== 4'b0000)
         $display("FAIL mid_restart_early: got %b, expected 0000", debounced);
      else passes++;
      wait_to(d + 12);
      checks++;
      if (debounced !== 4'b0011)
         $display("FAIL mid_restart_level: got %b, expected 0011", debounced);
      else passes++;
      wait_to(d + 20);
      signal = 4'b0000;
      exp_q.push_back(ev(d + 32, 4'b0000, 4'b0011, 4'b0000));
      wait_to(d + 34);
      checks++;
      if (debounced !== 4'b0000)
         $display("FAIL mid_release_level: got %b, expected 0000", debounced);
      else passes++;
   endtask

   task automatic test_random_glitches;
      int c;
      c = cyc;
      // bursts never hold one level for more than 8 cycles, so nothing may change
      while (cyc < c + 200) begin
         signal[3] = ~signal[3];
         repeat ($urandom_range(1, 8)) @(negedge clk);
      end
      signal[3] = 1'b0;
      wait_to(c + 230);
      checks++;
      if (debounced !== 4'b0000)
         $display("FAIL random_glitch_level: got %b, expected 0000", debounced);
      else passes++;
   endtask

   initial begin
      reset  = 1'b1;
      signal = 4'h0;
      @(negedge clk);
      test_reset;
      test_toggle_then_hold;
      test_short_pulse;
      test_long_press;
      test_simultaneous;
      test_reset_mid_count;
      test_random_glitches;
      repeat (60) @(negedge clk);
      checks++;
      if (exp_q.size() != 0)
         $display("FAIL missing_pulses: got %0d outstanding events, expected 0", exp_q.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
